// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_pkg
// Brief    : Flit ID encodings and arbiter state type shared by router blocks.
// Revision : 1.0
// ============================================================================
package noc_pkg;

  localparam int NOC_FLIT_ID_W = 2;

  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_BODY = 2'b10;
  localparam logic [1:0] FLIT_TAIL = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first request at or above ptr.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
  parameter int IN_N  = 5,
  parameter int IDX_W = $clog2(IN_N)
) (
  input  logic [IN_N-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IN_N-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < IN_N; k++) begin
      // walk the ring starting at ptr, wrapping past the last input
      j = int'(ptr) + k;
      if (j >= IN_N) j = j - IN_N;
      if (!any && req[j]) begin
        any    = 1'b1;
        idx    = IDX_W'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wormhole_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wormhole_out_arbiter
// Brief    : Output-port switch arbiter with wormhole locking and credits.
// Revision : 1.0
// ============================================================================
module wormhole_out_arbiter
  import noc_pkg::*;
#(
  parameter  int IN_N      = 5,
  parameter  int FLIT_ID_W = NOC_FLIT_ID_W,
  parameter  int BUF_DEPTH = 4,
  localparam int CRED_W    = $clog2(BUF_DEPTH + 1),
  localparam int SEL_W     = $clog2(IN_N)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [IN_N-1:0]           req_i,
  input  logic [IN_N*FLIT_ID_W-1:0] flit_id_i,
  input  logic [IN_N-1:0]           data_vld_i,
  input  logic                      credit_i,
  output logic [IN_N-1:0]           grant_o,
  output logic [SEL_W-1:0]          sel_o,
  output logic                      out_vld_o,
  output logic                      locked_o,
  output logic [CRED_W-1:0]         credits_o,
  output logic                      err_o
);

  arb_state_e          r_state;
  logic [SEL_W-1:0]    r_owner;
  logic [SEL_W-1:0]    r_ptr;
  logic [SEL_W-1:0]    r_sel;
  logic [CRED_W-1:0]   r_credits;
  logic                r_err;

  logic [FLIT_ID_W-1:0] w_flit [IN_N];
  logic [IN_N-1:0]      w_cand;
  logic [IN_N-1:0]      w_win_gnt;
  logic [SEL_W-1:0]     w_win_idx;
  logic                 w_win_any;
  logic                 w_has_cred;
  logic [FLIT_ID_W-1:0] w_owner_flit;

  always_comb begin
    for (int i = 0; i < IN_N; i++) begin
      w_flit[i] = flit_id_i[i*FLIT_ID_W +: FLIT_ID_W];
      w_cand[i] = req_i[i] && data_vld_i[i] && (w_flit[i] == FLIT_ID_W'(FLIT_HEAD));
    end
  end

  rr_arbiter #(
    .IN_N  (IN_N),
    .IDX_W (SEL_W)
  ) u_rr (
    .req (w_cand),
    .ptr (r_ptr),
    .gnt (w_win_gnt),
    .idx (w_win_idx),
    .any (w_win_any)
  );

  assign w_has_cred   = (r_credits != '0);
  assign w_owner_flit = w_flit[r_owner];

  // Transfer is same-cycle; gating uses only the registered credit count.
  always_comb begin
    grant_o   = '0;
    out_vld_o = 1'b0;
    sel_o     = r_sel;
    if (r_state == ST_LOCKED) begin
      sel_o = r_owner;
      if (!rst_i && data_vld_i[r_owner] && w_has_cred) begin
        grant_o[r_owner] = 1'b1;
        out_vld_o        = 1'b1;
      end
    end else if (w_win_any) begin
      sel_o = w_win_idx;
      if (!rst_i && w_has_cred) begin
        grant_o   = w_win_gnt;
        out_vld_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_sel     <= '0;
      r_credits <= CRED_W'(BUF_DEPTH);
      r_err     <= 1'b0;
    end else begin
      r_sel <= sel_o;

      // A grant and a returned credit in the same cycle cancel out.
      if (out_vld_o && !credit_i) begin
        r_credits <= r_credits - CRED_W'(1);
      end else if (credit_i && !out_vld_o) begin
        if (r_credits == CRED_W'(BUF_DEPTH)) r_err <= 1'b1;
        else                                  r_credits <= r_credits + CRED_W'(1);
      end

      if (out_vld_o) begin
        if (r_state == ST_IDLE) begin
          r_owner <= w_win_idx;
          r_state <= ST_LOCKED;
        end else if (w_owner_flit == FLIT_ID_W'(FLIT_TAIL)) begin
          r_state <= ST_IDLE;
          r_ptr   <= (r_owner == SEL_W'(IN_N - 1)) ? '0 : r_owner + SEL_W'(1);
        end else if (w_owner_flit == FLIT_ID_W'(FLIT_HEAD)) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign locked_o  = (r_state == ST_LOCKED);
  assign credits_o = r_credits;
  assign err_o     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_wormhole_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wormhole_out_arbiter
// Brief    : Directed self-checking bench for wormhole_out_arbiter.
// Revision : 1.0
// ============================================================================
module tb_wormhole_out_arbiter;

  localparam logic [1:0] HD = 2'b01;
  localparam logic [1:0] BD = 2'b10;
  localparam logic [1:0] TL = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req;
  logic [9:0] fid;
  logic [4:0] vld;
  logic       credit;
  logic [4:0] grant;
  logic [2:0] sel;
  logic       out_vld;
  logic       locked;
  logic [2:0] credits;
  logic       err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wormhole_out_arbiter #(
    .IN_N      (5),
    .FLIT_ID_W (2),
    .BUF_DEPTH (4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .flit_id_i  (fid),
    .data_vld_i (vld),
    .credit_i   (credit),
    .grant_o    (grant),
    .sel_o      (sel),
    .out_vld_o  (out_vld),
    .locked_o   (locked),
    .credits_o  (credits),
    .err_o      (err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear;
    req = '0; vld = '0; fid = '0; credit = 1'b0;
  endtask

  task automatic drive(input int i, input logic [1:0] id, input logic v);
    req[i] = v;
    vld[i] = v;
    fid[i*2 +: 2] = id;
  endtask

  task automatic test_reset;
    clear(); rst = 1'b1;
    drive(0, HD, 1'b1);
    tick(); tick();
    checks++;
    if ({grant, out_vld} !== 6'b0) begin
      errors++; $display("FAIL rst_hold_grant got %b exp %b", {grant, out_vld}, 6'b0);
    end
    rst = 1'b0; clear(); #1;
    checks++;
    if ({credits, grant, locked, err, out_vld, sel} !== {3'd4, 5'b0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      errors++; $display("FAIL reset_state got cred=%0d g=%b l=%b e=%b v=%b s=%0d exp cred=4 others 0",
                         credits, grant, locked, err, out_vld, sel);
    end
  endtask

  task automatic test_round_robin;
    drive(1, HD, 1'b1); drive(3, HD, 1'b1); credit = 1'b1; #1;
    checks++;
    if ({grant, sel, out_vld} !== {5'b00010, 3'd1, 1'b1}) begin
      errors++; $display("FAIL rr_win1 got g=%b s=%0d v=%b exp g=00010 s=1 v=1", grant, sel, out_vld);
    end
    tick(); drive(1, BD, 1'b1); #1;
    checks++;
    if ({grant, locked} !== {5'b00010, 1'b1}) begin
      errors++; $display("FAIL rr_body1 got g=%b l=%b exp g=00010 l=1", grant, locked);
    end
    tick(); drive(1, TL, 1'b1); #1;
    checks++;
    if (grant !== 5'b00010) begin
      errors++; $display("FAIL rr_tail1 got %b exp 00010", grant);
    end
    tick(); drive(1, 2'b00, 1'b0); #1;
    checks++;
    if ({grant, sel, locked} !== {5'b01000, 3'd3, 1'b0}) begin
      errors++; $display("FAIL rr_win3 got g=%b s=%0d l=%b exp g=01000 s=3 l=0", grant, sel, locked);
    end
    checks++;
    if (dut.r_ptr !== 3'd2) begin
      errors++; $display("FAIL rr_ptr2 got %0d exp 2", dut.r_ptr);
    end
    tick(); drive(3, TL, 1'b1); #1;
    checks++;
    if (grant !== 5'b01000) begin
      errors++; $display("FAIL rr_tail3 got %b exp 01000", grant);
    end
    tick(); drive(3, 2'b00, 1'b0); drive(0, HD, 1'b1); drive(4, HD, 1'b1); #1;
    checks++;
    if ({grant, sel, dut.r_ptr} !== {5'b10000, 3'd4, 3'd4}) begin
      errors++; $display("FAIL rr_ptr4 got g=%b s=%0d p=%0d exp g=10000 s=4 p=4", grant, sel, dut.r_ptr);
    end
    tick(); drive(0, 2'b00, 1'b0); drive(4, TL, 1'b1); #1;
    checks++;
    if ({grant, credits} !== {5'b10000, 3'd4}) begin
      errors++; $display("FAIL rr_tail4 got g=%b c=%0d exp g=10000 c=4", grant, credits);
    end
    tick(); clear(); #1;
  endtask

  task automatic test_stall_gap;
    drive(2, HD, 1'b1); credit = 1'b1; #1;
    checks++;
    if (grant !== 5'b00100) begin
      errors++; $display("FAIL gap_head got %b exp 00100", grant);
    end
    for (int k = 0; k < 3; k++) begin
      tick(); credit = 1'b0; drive(2, 2'b00, 1'b0); drive(0, HD, 1'b1); #1;
      checks++;
      if ({grant, locked, out_vld} !== {5'b0, 1'b1, 1'b0}) begin
        errors++; $display("FAIL gap_hold cyc %0d got g=%b l=%b v=%b exp g=0 l=1 v=0", k, grant, locked, out_vld);
      end
    end
    tick(); drive(2, BD, 1'b1); credit = 1'b1; #1;
    checks++;
    if ({grant, sel} !== {5'b00100, 3'd2}) begin
      errors++; $display("FAIL gap_resume got g=%b s=%0d exp g=00100 s=2", grant, sel);
    end
    tick(); drive(2, TL, 1'b1); #1;
    checks++;
    if (grant !== 5'b00100) begin
      errors++; $display("FAIL gap_tail got %b exp 00100", grant);
    end
    tick(); clear(); #1;
  endtask

  task automatic test_credit_stall;
    for (int k = 0; k < 4; k++) begin
      drive(0, (k == 0) ? HD : BD, 1'b1); #1;
      checks++;
      if (grant !== 5'b00001) begin
        errors++; $display("FAIL cs_grant %0d got %b exp 00001", k, grant);
      end
      tick();
    end
    drive(0, BD, 1'b1); #1;
    checks++;
    if ({credits, grant, locked} !== {3'd0, 5'b0, 1'b1}) begin
      errors++; $display("FAIL cs_stall got c=%0d g=%b l=%b exp c=0 g=0 l=1", credits, grant, locked);
    end
    credit = 1'b1; #1;
    checks++;
    if (grant !== 5'b0) begin
      errors++; $display("FAIL cs_same_cycle got %b exp 00000", grant);
    end
    tick(); credit = 1'b0; #1;
    checks++;
    if ({credits, grant} !== {3'd1, 5'b00001}) begin
      errors++; $display("FAIL cs_resume got c=%0d g=%b exp c=1 g=00001", credits, grant);
    end
    tick(); #1;
    checks++;
    if ({credits, grant} !== {3'd0, 5'b0}) begin
      errors++; $display("FAIL cs_restall got c=%0d g=%b exp c=0 g=0", credits, grant);
    end
    credit = 1'b1;
    tick(); credit = 1'b0; drive(0, TL, 1'b1); #1;
    checks++;
    if (grant !== 5'b00001) begin
      errors++; $display("FAIL cs_tail got %b exp 00001", grant);
    end
    tick(); clear(); #1;
    checks++;
    if ({locked, credits} !== {1'b0, 3'd0}) begin
      errors++; $display("FAIL cs_idle got l=%b c=%0d exp l=0 c=0", locked, credits);
    end
    credit = 1'b1;
    repeat (4) tick();
    checks++;
    if ({credits, err} !== {3'd4, 1'b0}) begin
      errors++; $display("FAIL cs_refill got c=%0d e=%b exp c=4 e=0", credits, err);
    end
    tick(); credit = 1'b0; #1;
    checks++;
    if ({credits, err} !== {3'd4, 1'b1}) begin
      errors++; $display("FAIL cs_overflow got c=%0d e=%b exp c=4 e=1", credits, err);
    end
    tick(); #1;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL cs_sticky got %b exp 1", err);
    end
  endtask

  task automatic test_credit_sim_and_reset;
    drive(1, HD, 1'b1); #1;
    checks++;
    if (grant !== 5'b00010) begin
      errors++; $display("FAIL sim_head got %b exp 00010", grant);
    end
    tick(); drive(1, BD, 1'b1); tick(); #1;
    checks++;
    if ({credits, grant} !== {3'd2, 5'b00010}) begin
      errors++; $display("FAIL sim_pre got c=%0d g=%b exp c=2 g=00010", credits, grant);
    end
    credit = 1'b1;
    tick(); credit = 1'b0; #1;
    checks++;
    if ({credits, locked} !== {3'd2, 1'b1}) begin
      errors++; $display("FAIL sim_cancel got c=%0d l=%b exp c=2 l=1", credits, locked);
    end
    rst = 1'b1; #1;
    checks++;
    if ({grant, out_vld} !== 6'b0) begin
      errors++; $display("FAIL mid_rst_force got %b exp 0", {grant, out_vld});
    end
    tick(); rst = 1'b0; #1;
    checks++;
    if ({locked, credits, err, dut.r_ptr} !== {1'b0, 3'd4, 1'b0, 3'd0}) begin
      errors++; $display("FAIL mid_rst_state got l=%b c=%0d e=%b p=%0d exp l=0 c=4 e=0 p=0",
                         locked, credits, err, dut.r_ptr);
    end
    checks++;
    if ({grant, out_vld} !== 6'b0) begin
      errors++; $display("FAIL mid_rst_body got g=%b v=%b exp 0", grant, out_vld);
    end
    tick(); clear(); #1;
  endtask

  task automatic test_head_in_lock;
    drive(0, HD, 1'b1); credit = 1'b1; #1;
    checks++;
    if (grant !== 5'b00001) begin
      errors++; $display("FAIL hl_head got %b exp 00001", grant);
    end
    tick(); #1;
    checks++;
    if ({grant, locked, err} !== {5'b00001, 1'b1, 1'b0}) begin
      errors++; $display("FAIL hl_second got g=%b l=%b e=%b exp g=00001 l=1 e=0", grant, locked, err);
    end
    tick(); drive(0, TL, 1'b1); #1;
    checks++;
    if ({grant, locked, err} !== {5'b00001, 1'b1, 1'b1}) begin
      errors++; $display("FAIL hl_err got g=%b l=%b e=%b exp g=00001 l=1 e=1", grant, locked, err);
    end
    tick(); clear(); drive(2, 2'b00, 1'b1); #1;
    checks++;
    if ({grant, locked, err} !== {5'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL hl_invalid_id got g=%b l=%b e=%b exp g=0 l=0 e=1", grant, locked, err);
    end
    clear();
  endtask

  initial begin
    clear(); rst = 1'b1;
    test_reset();
    test_round_robin();
    test_stall_gap();
    test_credit_stall();
    test_credit_sim_and_reset();
    test_head_in_lock();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
